// File: rtl/truth_table_prober.sv
// truth_table_prober: sweeps all input rows of an N-input gate and
// rebuilds its truth table. Option macro: PROBE_STABILITY_CHECK_EN.
module truth_table_prober #(
  parameter int N_IN          = 3,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic [N_IN-1:0]      stim,
  input  logic                 dut_out,
  output logic                 busy,
  output logic                 done,
  output logic [2**N_IN-1:0]   table_id,
  output logic                 table_valid,
  output logic                 unstable
);

  localparam int W  = 2**N_IN;
  localparam int RW = N_IN + 1;

  localparam logic [7:0]    RELOAD = 8'(SETTLE_CYCLES - 1);
  localparam logic [RW-1:0] LAST   = RW'(W - 1);

  if (N_IN < 1 || N_IN > 4) begin : g_bad_n_in
    $error("truth_table_prober: N_IN must be 1..4");
  end

  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 255) begin : g_bad_settle
    $error("truth_table_prober: SETTLE_CYCLES must be 1..255");
  end

  typedef enum logic [1:0] {
    IDLE,
    APPLY,
    DONE
  } state_t;

  state_t          state, state_n;
  logic [RW-1:0]   row, row_n;
  logic [RW-1:0]   nxt;
  logic [7:0]      cnt, cnt_n;
  logic [N_IN-1:0] stim_n;
  logic [N_IN-1:0] idx;
  logic [W-1:0]    tab_n;
  logic            tv_n;
  logic            adv;

`ifdef PROBE_STABILITY_CHECK_EN
  logic            chk, chk_n;
  logic            smp, smp_n;
  logic            uns, uns_n;
`endif

  assign nxt  = row + 1'b1;
  assign idx  = ~row[N_IN-1:0];
  assign busy = (state == APPLY);
  assign done = (state == DONE);

`ifdef PROBE_STABILITY_CHECK_EN
  assign unstable = uns;
`else
  assign unstable = 1'b0;
`endif

  // next-state and datapath updates for the sweep
  always_comb begin
    state_n = state;
    row_n   = row;
    cnt_n   = cnt;
    stim_n  = stim;
    tab_n   = table_id;
    tv_n    = table_valid;
    adv     = 1'b0;
`ifdef PROBE_STABILITY_CHECK_EN
    chk_n   = chk;
    smp_n   = smp;
    uns_n   = uns;
`endif
    unique case (state)
      IDLE: begin
        if (start) begin
          state_n = APPLY;
          row_n   = '0;
          cnt_n   = RELOAD;
          stim_n  = '0;
          tab_n   = '0;
          tv_n    = 1'b0;
`ifdef PROBE_STABILITY_CHECK_EN
          chk_n   = 1'b0;
          uns_n   = 1'b0;
`endif
        end
      end
      APPLY: begin
        if (cnt != 8'd0) begin
          cnt_n = cnt - 8'd1;
`ifdef PROBE_STABILITY_CHECK_EN
        end else if (!chk) begin
          tab_n[idx] = dut_out;
          smp_n      = dut_out;
          chk_n      = 1'b1;
        end else begin
          chk_n = 1'b0;
          if (dut_out != smp) begin
            uns_n = 1'b1;
          end
          adv = 1'b1;
        end
`else
        end else begin
          tab_n[idx] = dut_out;
          adv        = 1'b1;
        end
`endif
        if (adv) begin
          if (row == LAST) begin
            state_n = DONE;
            stim_n  = '0;
            tv_n    = 1'b1;
          end else begin
            row_n  = nxt;
            cnt_n  = RELOAD;
            stim_n = nxt[N_IN-1:0];
          end
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // state register; reset drops any partial table
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      row         <= '0;
      cnt         <= '0;
      stim        <= '0;
      table_id    <= '0;
      table_valid <= 1'b0;
`ifdef PROBE_STABILITY_CHECK_EN
      chk         <= 1'b0;
      smp         <= 1'b0;
      uns         <= 1'b0;
`endif
    end else begin
      state       <= state_n;
      row         <= row_n;
      cnt         <= cnt_n;
      stim        <= stim_n;
      table_id    <= tab_n;
      table_valid <= tv_n;
`ifdef PROBE_STABILITY_CHECK_EN
      chk         <= chk_n;
      smp         <= smp_n;
      uns         <= uns_n;
`endif
    end
  end

endmodule

// File: tb/tb_truth_table_prober.sv
// tb_truth_table_prober: scoreboard bench for truth_table_prober,
// default build and PROBE_STABILITY_CHECK_EN build.
module tb_truth_table_prober;

  localparam int WA = 8;
  localparam int SA = 4;
  localparam int WB = 4;
  localparam int SB = 1;
`ifdef PROBE_STABILITY_CHECK_EN
  localparam int LA   = SA + 1;
  localparam int LB   = SB + 1;
  localparam bit STAB = 1'b1;
`else
  localparam int LA   = SA;
  localparam int LB   = SB;
  localparam bit STAB = 1'b0;
`endif

  typedef struct {
    logic [7:0] tab;
    logic       uns;
    int         edge_n;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_a = 1'b0;
  logic       start_b = 1'b0;
  logic [2:0] stim_a;
  logic [1:0] stim_b;
  logic       dut_out_a, dut_out_b;
  logic       busy_a, busy_b, done_a, done_b;
  logic [7:0] table_id_a;
  logic [3:0] table_id_b;
  logic       table_valid_a, table_valid_b;
  logic       unstable_a, unstable_b;

  logic [7:0] gate_a = 8'h00;
  logic [3:0] gate_b = 4'h0;
  logic       glitch_a = 1'b0;

  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  exp_t q_a[$];
  exp_t q_b[$];
  bit         tv_a_exp = 1'b0;
  logic [7:0] prev_a = 8'h00;

  truth_table_prober #(.N_IN(3), .SETTLE_CYCLES(SA)) u_a (
    .clk(clk), .rst(rst), .start(start_a), .stim(stim_a),
    .dut_out(dut_out_a), .busy(busy_a), .done(done_a),
    .table_id(table_id_a), .table_valid(table_valid_a),
    .unstable(unstable_a)
  );

  truth_table_prober #(.N_IN(2), .SETTLE_CYCLES(SB)) u_b (
    .clk(clk), .rst(rst), .start(start_b), .stim(stim_b),
    .dut_out(dut_out_b), .busy(busy_b), .done(done_b),
    .table_id(table_id_b), .table_valid(table_valid_b),
    .unstable(unstable_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // gate models: row r of the table is bit (W-1-r) of the id
  always_comb begin
    dut_out_a = gate_a[WA-1-int'(stim_a)] ^ glitch_a;
    dut_out_b = gate_b[WB-1-int'(stim_b)];
  end

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, req,
               $time);
    end
  endtask

  // g: edge (relative to the start edge) at which dut_out is inverted
  function automatic exp_t model(input logic [7:0] code, input int w,
                                 input int l, input int s, input int g,
                                 input int st);
    exp_t e;
    e.tab = '0;
    e.uns = 1'b0;
    for (int r = 0; r < w; r++) begin
      int sm = l * r + s;
      e.tab[w-1-r] = code[w-1-r] ^ (g == sm);
      if (STAB && ((g == sm) != (g == sm + 1))) e.uns = 1'b1;
    end
    e.edge_n = st + w * l;
    return e;
  endfunction

  // monitor: compare each done pulse with the scoreboard
  always @(posedge clk) begin
    exp_t ea, eb;
    #1;
    if (done_a) begin
      if (q_a.size() == 0) begin
        check("a_unexpected_done", 1, 0);
      end else begin
        ea = q_a.pop_front();
        check("a_table_id", table_id_a, ea.tab);
        check("a_unstable", unstable_a, ea.uns);
        check("a_done_edge", cyc, ea.edge_n);
        check("a_valid_at_done", table_valid_a, 1);
        check("a_busy_at_done", busy_a, 0);
        check("a_stim_at_done", stim_a, 0);
      end
    end
    if (done_b) begin
      if (q_b.size() == 0) begin
        check("b_unexpected_done", 1, 0);
      end else begin
        eb = q_b.pop_front();
        check("b_table_id", table_id_b, eb.tab);
        check("b_done_edge", cyc, eb.edge_n);
        check("b_unstable", unstable_b, 0);
      end
    end
  end

  task automatic sweep_a(input logic [7:0] code, input int g,
                         input bit poke);
    int st;
    exp_t e;
    gate_a = code;
    if (tv_a_exp) begin
      check("a_idle_valid", table_valid_a, 1);
      check("a_idle_table", table_id_a, prev_a);
    end
    st = cyc + 1;
    e  = model(code, WA, LA, SA, g, st);
    q_a.push_back(e);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    check("a_start_valid_drop", table_valid_a, 0);
    check("a_start_table_clr", table_id_a, 0);
    for (int k = 1; k <= WA * LA + 1; k++) begin
      int j = k - 1;
      check("a_stim", stim_a, (j < WA * LA) ? j / LA : 0);
      check("a_busy", busy_a, (j < WA * LA) ? 1 : 0);
      glitch_a = (k == g);
      start_a  = poke && (k == 5 || k == 17);
      @(negedge clk);
    end
    glitch_a = 1'b0;
    start_a  = 1'b0;
    tv_a_exp = 1'b1;
    prev_a   = e.tab;
  endtask

  task automatic reset_mid();
    gate_a  = 8'h4A;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (12) @(negedge clk);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("rst_stim", stim_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_table", table_id_a, 0);
    check("rst_valid", table_valid_a, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_stays_idle", busy_a, 0);
    tv_a_exp = 1'b0;
  endtask

  task automatic back_to_back(input logic [7:0] code);
    int st;
    gate_a = code;
    st = cyc + 1;
    q_a.push_back(model(code, WA, LA, SA, -1, st));
    q_a.push_back(model(code, WA, LA, SA, -1, st + WA * LA + 2));
    start_a = 1'b1;
    repeat (WA * LA + 3) @(negedge clk);
    start_a = 1'b0;
    check("b2b_second_busy", busy_a, 1);
    repeat (WA * LA + 1) @(negedge clk);
    check("b2b_idle", busy_a, 0);
    tv_a_exp = 1'b1;
    prev_a   = code;
  endtask

  task automatic sweep_b(input logic [3:0] code);
    int st;
    gate_b = code;
    st = cyc + 1;
    q_b.push_back(model({4'h0, code}, WB, LB, SB, -1, st));
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    check("b_busy", busy_b, 1);
    repeat (WB * LB + 1) @(negedge clk);
  endtask

  initial begin
    #2;
    check("reset_stim", stim_a, 0);
    check("reset_busy", busy_a, 0);
    check("reset_done", done_a, 0);
    check("reset_table", table_id_a, 0);
    check("reset_valid", table_valid_a, 0);
    check("reset_unstable", unstable_a, 0);
    check("reset_b_table", table_id_b, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    sweep_a(8'h4A, -1, 1'b0);
    sweep_a(8'hFF, -1, 1'b0);
    sweep_a(8'h00, -1, 1'b0);
    sweep_a(8'h4A, -1, 1'b1);
    reset_mid();
    sweep_a(8'hC3, -1, 1'b0);
    sweep_a(8'h4A, LA * 3 + SA, 1'b0);
    back_to_back(8'h5A);

    sweep_b(4'b0110);
    for (int i = 0; i < 3; i++) sweep_b(4'($urandom));

    for (int i = 0; i < 6; i++) begin
      int g;
      g = ($urandom_range(0, 2) == 0) ? -1
          : int'($urandom_range(1, WA * LA));
      sweep_a(8'($urandom), g, 1'($urandom));
    end

    repeat (3) @(negedge clk);
    check("a_queue_drained", q_a.size(), 0);
    check("b_queue_drained", q_b.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/truth_table_prober.md
Name: truth_table_prober

Overview:
- Sequential stimulus/capture engine that sweeps every input combination of an N-input combinational logic block (one truth-table gate circuit) and reconstructs its truth-table identifier, e.g. 0x4A.
- It is the driving side of the gate interface: it produces the input vector, waits for the output to settle, samples it, and assembles the 2^N-bit table.
- Used in simulation and on-chip self-check harnesses around the generated gate modules.

Parameters:
- N_IN, 3, number of gate inputs; table width is 2**N_IN; legal range 1..4.
- SETTLE_CYCLES, 4, clock cycles each input vector is held before sampling; legal range 1..255; 0 is illegal and must fail elaboration.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  reset; asynchronous, active-high.
- start  input  1  sweep request, sampled in IDLE only.
- stim  output  N_IN  vector driven to the gate; stim[N_IN-1] drives in1, stim[0] drives the last input.
- dut_out  input  1  gate output being probed.
- busy  output  1  high while a sweep is in progress.
- done  output  1  one-cycle pulse when the table is complete.
- table_id  output  2**N_IN  captured truth table.
- table_valid  output  1  high from done until the next accepted start or reset.
- unstable  output  1  stability flag (see Optional Feature).

Behaviour:
- Reset values: stim=0, busy=0, done=0, table_id=0, table_valid=0, unstable=0, state=IDLE, row=0, settle counter=0.
- Reset is honoured mid-sweep: all state returns to IDLE immediately and no partial table is retained.
- States:
  - IDLE: start=1 at an edge gives APPLY, row=0, stim=0, busy=1, table_id=0, table_valid=0, unstable=0, counter loaded with SETTLE_CYCLES-1.
  - APPLY: stim=row. The counter decrements each edge. At the edge where the counter is 0, dut_out is captured into table_id bit (2**N_IN-1-row), so row 0 maps to the MSB.
  - After the capture: if row < 2**N_IN-1, row increments and the counter reloads, staying in APPLY. Otherwise go to DONE.
  - DONE: lasts exactly one cycle with done=1, table_valid=1, busy=0, stim=0, then IDLE.
- Timing: the start-sampling edge is edge 0. Row k is captured at edge SETTLE_CYCLES*(k+1). done=1 in the cycle following edge 2**N_IN*SETTLE_CYCLES. For the defaults, row 0 is captured at edge 4, row 7 at edge 32, and done is high during cycle 32-33.
- start while busy or in DONE is ignored; no queuing.
- start held high continuously gives back-to-back sweeps separated by the DONE cycle and the IDLE acceptance edge.
- stim changes only at row boundaries. It never glitches through intermediate values because it is a registered output.
- table_id is stable while table_valid=1. During a sweep it shows bits captured so far; other bits are 0.
- Row counter width is N_IN+1 bits, so it does not wrap at 2**N_IN-1.

Optional Feature:
- Macro: PROBE_STABILITY_CHECK_EN.
- Enabled:
  - Each row lasts SETTLE_CYCLES+1 cycles.
  - dut_out is captured at the edge where the counter reaches 0 and compared at the following edge.
  - On any mismatch, unstable is set and held until the next accepted start or reset. The first sample is stored in table_id.
  - done follows edge 2**N_IN*(SETTLE_CYCLES+1), which is 40 for the defaults.
- Disabled: row timing is as in Behaviour, and unstable is tied to 0.

Test Plan:
- Gate model 0x4A (000→0, 001→1, 100→1, 110→1, else 0), defaults, start pulse at edge 0 → stim steps 0..7 every 4 cycles; done pulse after edge 32; table_id=0x4A; table_valid=1; busy low in the done cycle.
- dut_out tied 1, then tied 0 → table_id=0xFF, then 0x00 on the second sweep. table_valid drops at the second start.
- start pulsed repeatedly mid-sweep (edges 5, 17) → no restart; done still after edge 32; table_id unchanged from the expected value.
- rst asserted asynchronously at cycle 13 → stim=0, busy=0, table_id=0 before the next edge; a new start then produces a correct full sweep.
- N_IN=2, SETTLE_CYCLES=1, XOR model → table_id=4'b0110; done after edge 4.
- With PROBE_STABILITY_CHECK_EN, dut_out flipped for one cycle exactly at the sample edge of row 3 → unstable=1 at done, done after edge 40. Without the macro, the same stimulus gives unstable=0.
